// File: rtl/cpu_pkg.sv
// cpu_pkg: shared widths, loader state encoding and error codes for the boot loader.
//   ADDR_W / INSTR_W : instruction memory address / word widths
//   MAX_WORDS        : longest program that fits below the CPU's stop address
package cpu_pkg;
    localparam int ADDR_W    = 10;
    localparam int INSTR_W   = 18;
    localparam int MAX_WORDS = 1022;

    typedef enum logic [2:0] {
        IDLE,
        LEN_LO,
        LEN_HI,
        DATA,
        CHECK,
        DONE,
        ERROR
    } loader_state_t;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_LENGTH   = 2'd1;
    localparam logic [1:0] ERR_FORMAT   = 2'd2;
    localparam logic [1:0] ERR_CHECKSUM = 2'd3;
endpackage

// File: rtl/word_packer.sv
// word_packer: assembles three little-endian stream bytes into one instruction word.
//   clk, reset : clock, asynchronous active-high reset
//   clear      : restart at byte 0 (new session)
//   byte_en    : a payload byte is transferred this cycle
//   in_byte    : the payload byte
//   word_valid : this cycle's byte completes a word (b2)
//   word       : {b2[1:0], b1, b0}, meaningful while word_valid
//   fmt_err    : b2 has bits set above the word width, meaningful while word_valid
module word_packer
    import cpu_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic               byte_en,
    input  logic [7:0]         in_byte,
    output logic               word_valid,
    output logic [INSTR_W-1:0] word,
    output logic               fmt_err
);
    logic [1:0] idx;
    logic [7:0] b0, b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx <= 2'd0;
            b0  <= 8'd0;
            b1  <= 8'd0;
        end else if (clear) begin
            idx <= 2'd0;
        end else if (byte_en) begin
            idx <= (idx == 2'd2) ? 2'd0 : idx + 2'd1;
            if (idx == 2'd0) b0 <= in_byte;
            if (idx == 2'd1) b1 <= in_byte;
        end
    end

    // b2 is consumed directly from the stream so the word is ready in its transfer cycle
    assign word_valid = byte_en && (idx == 2'd2);
    assign word       = {in_byte[1:0], b1, b0};
    assign fmt_err    = |in_byte[7:2];
endmodule

// File: rtl/program_loader.sv
// program_loader: boot loader streaming a checksummed program into instruction memory, then releasing the CPU.
//   clk, reset            : clock, asynchronous active-high reset
//   start                 : one-cycle pulse opening a session (ignored while busy)
//   in_valid/in_byte      : byte stream source; in_ready accepts it
//   imem_we/addr/wdata    : one-cycle write per assembled word
//   cpu_hold              : CPU reset, released only on a verified load
//   busy, done, error     : session status; done/error sticky until next start
//   err_code              : 0 none, 1 length, 2 format, 3 checksum
//   words_loaded          : words written in the current session
module program_loader
    import cpu_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               in_valid,
    input  logic [7:0]         in_byte,
    output logic               in_ready,
    output logic               imem_we,
    output logic [ADDR_W-1:0]  imem_addr,
    output logic [INSTR_W-1:0] imem_wdata,
    output logic               cpu_hold,
    output logic               busy,
    output logic               done,
    output logic               error,
    output logic [1:0]         err_code,
    output logic [ADDR_W:0]    words_loaded
);
    loader_state_t      state;
    logic [ADDR_W:0]    n_words;
    logic [7:0]         chk;
    logic               xfer, start_ok, word_valid, fmt_err;
    logic [ADDR_W:0]    len;
    logic [INSTR_W-1:0] word;

    always_comb begin
        xfer     = in_valid && in_ready;
        start_ok = start && (state == IDLE || state == DONE || state == ERROR);
        len      = {in_byte[2:0], n_words[7:0]};
    end

    word_packer u_packer (
        .clk        (clk),
        .reset      (reset),
        .clear      (start_ok),
        .byte_en    (xfer && state == DATA),
        .in_byte    (in_byte),
        .word_valid (word_valid),
        .word       (word),
        .fmt_err    (fmt_err)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            n_words      <= '0;
            chk          <= 8'd0;
            in_ready     <= 1'b0;
            imem_we      <= 1'b0;
            imem_addr    <= '0;
            imem_wdata   <= '0;
            cpu_hold     <= 1'b1;
            busy         <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
            err_code     <= ERR_NONE;
            words_loaded <= '0;
        end else begin
            imem_we <= 1'b0;
            if (start_ok) begin
                state        <= LEN_LO;
                in_ready     <= 1'b1;
                busy         <= 1'b1;
                cpu_hold     <= 1'b1;
                chk          <= 8'd0;
                words_loaded <= '0;
                done         <= 1'b0;
                error        <= 1'b0;
                err_code     <= ERR_NONE;
            end else if (xfer) begin
                case (state)
                    LEN_LO: begin
                        n_words <= {3'd0, in_byte};
                        state   <= LEN_HI;
                    end
                    LEN_HI: begin
                        n_words <= len;
                        if (len == '0 || len > (ADDR_W+1)'(MAX_WORDS)) begin
                            state    <= ERROR;
                            in_ready <= 1'b0;
                            busy     <= 1'b0;
                            error    <= 1'b1;
                            err_code <= ERR_LENGTH;
                        end else begin
                            state <= DATA;
                        end
                    end
                    DATA: begin
                        chk <= chk ^ in_byte;
                        if (word_valid && fmt_err) begin
                            state    <= ERROR;
                            in_ready <= 1'b0;
                            busy     <= 1'b0;
                            error    <= 1'b1;
                            err_code <= ERR_FORMAT;
                        end else if (word_valid) begin
                            imem_we      <= 1'b1;
                            imem_addr    <= words_loaded[ADDR_W-1:0];
                            imem_wdata   <= word;
                            words_loaded <= words_loaded + 1'b1;
                            if (words_loaded + 1'b1 == n_words) state <= CHECK;
                        end
                    end
                    CHECK: begin
                        in_ready <= 1'b0;
                        busy     <= 1'b0;
                        if (in_byte == chk) begin
                            state    <= DONE;
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
                        end else begin
                            state    <= ERROR;
                            error    <= 1'b1;
                            err_code <= ERR_CHECKSUM;
                        end
                    end
                    default: state <= state;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: directed self-checking bench for program_loader.
module tb_program_loader;
    logic        clk = 1'b0;
    logic        reset, start, in_valid;
    logic [7:0]  in_byte;
    logic        in_ready, imem_we, cpu_hold, busy, done, error;
    logic [9:0]  imem_addr;
    logic [17:0] imem_wdata;
    logic [1:0]  err_code;
    logic [10:0] words_loaded;

    int          n_checks = 0;
    int          n_errors = 0;
    int          we_count = 0;
    int          we_base;
    logic [17:0] mem [1024];
    logic [17:0] wq [$];

    program_loader dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .in_valid     (in_valid),
        .in_byte      (in_byte),
        .in_ready     (in_ready),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_wdata   (imem_wdata),
        .cpu_hold     (cpu_hold),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .err_code     (err_code),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // memory model and write-side consistency, sampled mid-cycle
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            we_count++;
            mem[imem_addr] = imem_wdata;
            check("wl_with_we", 32'(words_loaded), 32'(imem_addr) + 1);
        end
    end

    task automatic check_reset_values(input string tag);
        check({tag, "_in_ready"}, 32'(in_ready), 0);
        check({tag, "_imem_we"}, 32'(imem_we), 0);
        check({tag, "_imem_addr"}, 32'(imem_addr), 0);
        check({tag, "_imem_wdata"}, 32'(imem_wdata), 0);
        check({tag, "_cpu_hold"}, 32'(cpu_hold), 1);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_done"}, 32'(done), 0);
        check({tag, "_error"}, 32'(error), 0);
        check({tag, "_err_code"}, 32'(err_code), 0);
        check({tag, "_words_loaded"}, 32'(words_loaded), 0);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("ready_after_start", 32'(in_ready), 1);
        check("busy_after_start", 32'(busy), 1);
    endtask

    // called and returning at a negedge; returns once the byte has transferred
    task automatic send_byte(input logic [7:0] b, input int gap);
        bit sent = 1'b0;
        in_valid = 1'b0;
        repeat (gap) @(negedge clk);
        in_valid = 1'b1;
        in_byte  = b;
        for (int i = 0; i < 20 && !sent; i++) begin
            if (in_ready) begin
                @(posedge clk);
                sent = 1'b1;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        if (!sent) check("ready_timeout", 0, 1);
    endtask

    // streams header plus the words in wq; stops early after stop_after words, else sends CHK
    task automatic send_words(input int max_gap, input int stop_after, input bit bad_chk);
        int         n   = wq.size();
        logic [7:0] c   = 8'd0;
        logic [17:0] w;
        send_byte(8'(n), 0);
        send_byte({5'd0, 3'(n >> 8)}, 0);
        for (int i = 0; i < n; i++) begin
            if (i == stop_after) return;
            w = wq[i];
            send_byte(w[7:0], max_gap ? $urandom_range(0, max_gap) : 0);
            send_byte(w[15:8], max_gap ? $urandom_range(0, max_gap) : 0);
            send_byte({6'd0, w[17:16]}, max_gap ? $urandom_range(0, max_gap) : 0);
            c = c ^ w[7:0] ^ w[15:8] ^ {6'd0, w[17:16]};
        end
        send_byte(bad_chk ? c ^ 8'h01 : c, max_gap ? $urandom_range(0, max_gap) : 0);
    endtask

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_byte  = 8'd0;
        repeat (2) @(negedge clk);
        check_reset_values("rst");
        reset = 1'b0;
        @(negedge clk);

        // N=2 literal stream
        we_base = we_count;
        pulse_start();
        send_byte(8'h02, 0); send_byte(8'h00, 0);
        send_byte(8'hFF, 0); send_byte(8'hFF, 0); send_byte(8'h03, 0);
        send_byte(8'h01, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
        send_byte(8'h02, 0);
        check("n2_mem0", 32'(mem[0]), 32'h3FFFF);
        check("n2_mem1", 32'(mem[1]), 32'h00001);
        check("n2_done", 32'(done), 1);
        check("n2_error", 32'(error), 0);
        check("n2_cpu_hold", 32'(cpu_hold), 0);
        check("n2_words", 32'(words_loaded), 2);
        check("n2_we_count", 32'(we_count - we_base), 2);
        check("n2_ready", 32'(in_ready), 0);
        check("n2_busy", 32'(busy), 0);

        // N=0
        we_base = we_count;
        pulse_start();
        check("restart_done_clr", 32'(done), 0);
        check("restart_hold", 32'(cpu_hold), 1);
        send_byte(8'h00, 0); send_byte(8'h00, 0);
        check("n0_error", 32'(error), 1);
        check("n0_code", 32'(err_code), 1);
        check("n0_hold", 32'(cpu_hold), 1);
        check("n0_ready", 32'(in_ready), 0);

        // N=1023, plus ignored LEN_HI upper bits
        pulse_start();
        check("restart_err_clr", 32'(error), 0);
        send_byte(8'hFF, 0); send_byte(8'hFB, 0);
        check("n1023_error", 32'(error), 1);
        check("n1023_code", 32'(err_code), 1);
        check("n1023_hold", 32'(cpu_hold), 1);
        repeat (3) @(negedge clk);
        check("len_no_we", 32'(we_count - we_base), 0);

        // N=1 with b2 format violation
        we_base = we_count;
        pulse_start();
        send_byte(8'h01, 0); send_byte(8'h00, 0);
        send_byte(8'hAA, 0); send_byte(8'hBB, 0); send_byte(8'h04, 0);
        repeat (2) @(negedge clk);
        check("fmt_error", 32'(error), 1);
        check("fmt_code", 32'(err_code), 2);
        check("fmt_words", 32'(words_loaded), 0);
        check("fmt_no_we", 32'(we_count - we_base), 0);

        // N=1 with wrong CHK (correct would be 11^22^03 = 30)
        we_base = we_count;
        pulse_start();
        send_byte(8'h01, 0); send_byte(8'h00, 0);
        send_byte(8'h11, 0); send_byte(8'h22, 0); send_byte(8'h03, 0);
        send_byte(8'h31, 0);
        check("chk_mem0", 32'(mem[0]), 32'h32211);
        check("chk_we", 32'(we_count - we_base), 1);
        check("chk_error", 32'(error), 1);
        check("chk_code", 32'(err_code), 3);
        check("chk_done", 32'(done), 0);
        check("chk_hold", 32'(cpu_hold), 1);
        check("chk_words", 32'(words_loaded), 1);

        // N=5 with random in_valid gaps
        wq = '{18'h3A5C1, 18'h00000, 18'h1FFFF, 18'h20080, 18'h0F0F0};
        we_base = we_count;
        pulse_start();
        send_words(3, 99, 1'b0);
        for (int i = 0; i < 5; i++) check($sformatf("gap_mem%0d", i), 32'(mem[i]), 32'(wq[i]));
        check("gap_we", 32'(we_count - we_base), 5);
        check("gap_done", 32'(done), 1);
        check("gap_hold", 32'(cpu_hold), 0);
        check("gap_words", 32'(words_loaded), 5);

        // reset after 2 of 4 words, then a clean reload
        wq = '{18'h12345, 18'h2ABCD, 18'h00FF0, 18'h3C3C3};
        pulse_start();
        send_words(0, 2, 1'b0);
        check("mid_words", 32'(words_loaded), 2);
        reset = 1'b1;
        #1;
        check_reset_values("midrst");
        @(negedge clk);
        check_reset_values("midrst_hold");
        reset = 1'b0;
        @(negedge clk);
        we_base = we_count;
        pulse_start();
        send_words(0, 99, 1'b0);
        for (int i = 0; i < 4; i++) check($sformatf("reload_mem%0d", i), 32'(mem[i]), 32'(wq[i]));
        check("reload_we", 32'(we_count - we_base), 4);
        check("reload_done", 32'(done), 1);
        check("reload_hold", 32'(cpu_hold), 0);
        check("reload_words", 32'(words_loaded), 4);

        // start is ignored while busy
        pulse_start();
        send_byte(8'h01, 0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        send_byte(8'h00, 0);
        send_byte(8'h05, 0); send_byte(8'h06, 0); send_byte(8'h01, 0);
        send_byte(8'h02, 0);
        check("busy_start_mem0", 32'(mem[0]), 32'h10605);
        check("busy_start_done", 32'(done), 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
